ram_port_arbiter: RTL and testbench

RAM_PORT_ARBITER -- requirements
Module: ram_port_arbiter

---
 rtl/ram_arb_pkg.sv | 12 +
 rtl/arb_rr2.sv | 35 +++
 rtl/ram_port_arbiter.sv | 125 ++++++++++++
 tb/tb_ram_port_arbiter.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/ram_arb_pkg.sv
// Shared types and default widths for the two-requester RAM port arbiter.
package ram_arb_pkg;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int DATA_W_DEF = 16;
    localparam int ADDR_W_DEF = 4;

endpackage

// File: rtl/arb_rr2.sv
// Two-way round-robin resolver for write-write conflicts; owns the priority bit.
module arb_rr2 (
    input  logic clk,
    input  logic rst,
    input  logic conflict,
    input  logic req0,
    input  logic req1,
    output logic gnt0,
    output logic gnt1
);

    logic prio_q;
    logic prio_d;

    always_comb begin
        prio_d = prio_q;
        gnt0   = req0;
        gnt1   = req1;
        // prio_q == 0 favours requester 0; flip after every conflict so winners alternate
        if (conflict) begin
            gnt0   = ~prio_q;
            gnt1   = prio_q;
            prio_d = ~prio_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prio_q <= 1'b0;
        end else begin
            prio_q <= prio_d;
        end
    end

endmodule

// File: rtl/ram_port_arbiter.sv
// Maps two requesters onto an external dual-port RAM, clears the RAM after reset
// and resolves same-address write collisions round-robin.
module ram_port_arbiter
    import ram_arb_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] adr0,
    input  logic [ADDR_W-1:0] adr1,
    input  logic [DATA_W-1:0] wd0,
    input  logic [DATA_W-1:0] wd1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rd0,
    output logic [DATA_W-1:0] rd1,
    output logic              ram_we_a,
    output logic              ram_we_b,
    output logic [ADDR_W-1:0] ram_adr_a,
    output logic [ADDR_W-1:0] ram_adr_b,
    output logic [DATA_W-1:0] ram_din_a,
    output logic [DATA_W-1:0] ram_din_b,
    input  logic [DATA_W-1:0] ram_dout_a,
    input  logic [DATA_W-1:0] ram_dout_b,
    output logic              busy,
    output logic [7:0]        conflict_cnt
);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] init_adr_q, init_adr_d;
    logic [7:0]        conflict_cnt_q, conflict_cnt_d;
    logic              rvalid0_q, rvalid0_d;
    logic              rvalid1_q, rvalid1_d;

    logic run;
    logic conflict;
    logic arb_gnt0;
    logic arb_gnt1;

    assign run      = (state_q == RUN);
    assign conflict = run & req0 & req1 & we0 & we1 & (adr0 == adr1);

    arb_rr2 u_arb (
        .clk      (clk),
        .rst      (rst),
        .conflict (conflict),
        .req0     (req0),
        .req1     (req1),
        .gnt0     (arb_gnt0),
        .gnt1     (arb_gnt1)
    );

    always_comb begin
        state_d        = state_q;
        init_adr_d     = init_adr_q;
        conflict_cnt_d = conflict_cnt_q;
        gnt0           = 1'b0;
        gnt1           = 1'b0;
        ram_we_a       = 1'b0;
        ram_we_b       = 1'b0;
        ram_adr_a      = adr0;
        ram_adr_b      = adr1;
        ram_din_a      = wd0;
        ram_din_b      = wd1;
        busy           = 1'b0;

        case (state_q)
            INIT: begin
                // Requests are dropped here, not queued; requesters simply keep req high
                busy       = 1'b1;
                ram_we_a   = 1'b1;
                ram_adr_a  = init_adr_q;
                ram_din_a  = '0;
                init_adr_d = init_adr_q + 1'b1;
                if (init_adr_q == {ADDR_W{1'b1}}) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                gnt0     = arb_gnt0;
                gnt1     = arb_gnt1;
                ram_we_a = arb_gnt0 & we0;
                ram_we_b = arb_gnt1 & we1;
                if (conflict && conflict_cnt_q != 8'hFF) begin
                    conflict_cnt_d = conflict_cnt_q + 8'd1;
                end
            end
            default: state_d = INIT;
        endcase

        rvalid0_d = gnt0 & ~we0;
        rvalid1_d = gnt1 & ~we1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= INIT;
            init_adr_q     <= '0;
            conflict_cnt_q <= '0;
            rvalid0_q      <= 1'b0;
            rvalid1_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            init_adr_q     <= init_adr_d;
            conflict_cnt_q <= conflict_cnt_d;
            rvalid0_q      <= rvalid0_d;
            rvalid1_q      <= rvalid1_d;
        end
    end

    assign rvalid0      = rvalid0_q;
    assign rvalid1      = rvalid1_q;
    assign rd0          = ram_dout_a;
    assign rd1          = ram_dout_b;
    assign conflict_cnt = conflict_cnt_q;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter with a read-first dual-port RAM model and
// a read-data scoreboard.
module tb_ram_port_arbiter;

    localparam int DW = 16;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          req0, req1, we0, we1;
    logic [AW-1:0] adr0, adr1;
    logic [DW-1:0] wd0, wd1;
    logic          gnt0, gnt1, rvalid0, rvalid1;
    logic [DW-1:0] rd0, rd1;
    logic          ram_we_a, ram_we_b;
    logic [AW-1:0] ram_adr_a, ram_adr_b;
    logic [DW-1:0] ram_din_a, ram_din_b;
    logic [DW-1:0] ram_dout_a, ram_dout_b;
    logic          busy;
    logic [7:0]    conflict_cnt;

    logic [DW-1:0] mem [1<<AW];
    logic [DW-1:0] q0 [$];
    logic [DW-1:0] q1 [$];
    int            checks = 0;
    int            errors = 0;
    bit            done   = 1'b0;

    always #5 clk = ~clk;

    ram_port_arbiter #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .adr0(adr0), .adr1(adr1), .wd0(wd0), .wd1(wd1),
        .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
        .rd0(rd0), .rd1(rd1),
        .ram_we_a(ram_we_a), .ram_we_b(ram_we_b),
        .ram_adr_a(ram_adr_a), .ram_adr_b(ram_adr_b),
        .ram_din_a(ram_din_a), .ram_din_b(ram_din_b),
        .ram_dout_a(ram_dout_a), .ram_dout_b(ram_dout_b),
        .busy(busy), .conflict_cnt(conflict_cnt)
    );

    // Read-first RAM: registered read returns the contents before this edge's write
    always @(posedge clk) begin
        ram_dout_a <= mem[ram_adr_a];
        ram_dout_b <= mem[ram_adr_b];
        if (ram_we_a) mem[ram_adr_a] <= ram_din_a;
        if (ram_we_b) mem[ram_adr_b] <= ram_din_b;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set0(input logic r, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req0 = r; we0 = w; adr0 = a; wd0 = d;
    endtask

    task automatic set1(input logic r, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req1 = r; we1 = w; adr1 = a; wd1 = d;
    endtask

    // Monitor: pop expected read data whenever a requester sees rvalid
    initial begin
        logic [DW-1:0] e;
        while (!done) begin
            @(negedge clk);
            if (ram_we_a === 1'b1 && ram_we_b === 1'b1)
                chk("dual_write_same_adr", {28'd0, ram_adr_a == ram_adr_b}, 32'd0);
            if (rvalid0 === 1'b1) begin
                if (q0.size() == 0) chk("rvalid0_unexpected", 32'd1, 32'd0);
                else begin e = q0.pop_front(); chk("rd0", {16'd0, rd0}, {16'd0, e}); end
            end
            if (rvalid1 === 1'b1) begin
                if (q1.size() == 0) chk("rvalid1_unexpected", 32'd1, 32'd0);
                else begin e = q1.pop_front(); chk("rd1", {16'd0, rd1}, {16'd0, e}); end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        set0(0, 0, 0, 0);
        set1(0, 0, 0, 0);
        step();
        step();
        rst = 1'b0;
        set0(1, 0, 4'd9, 16'h0);
        // Clear sequence: requests must be ignored while busy
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            chk("init_busy", {31'd0, busy}, 32'd1);
            chk("init_we_a", {31'd0, ram_we_a}, 32'd1);
            chk("init_adr_a", {28'd0, ram_adr_a}, i);
            chk("init_din_a", {16'd0, ram_din_a}, 32'd0);
            chk("init_gnt0", {31'd0, gnt0}, 32'd0);
            chk("init_we_b", {31'd0, ram_we_b}, 32'd0);
            if (i == 0) begin
                chk("reset_cnt", {24'd0, conflict_cnt}, 32'd0);
                chk("reset_rvalid0", {31'd0, rvalid0}, 32'd0);
            end
            step();
        end
        @(negedge clk);
        chk("run_busy", {31'd0, busy}, 32'd0);
        chk("run_gnt0_read9", {31'd0, gnt0}, 32'd1);
        q0.push_back(16'h0000);
        step();
        set0(0, 0, 0, 0);

        // Write then read back through the other port
        set0(1, 1, 4'd3, 16'hBEEF);
        @(negedge clk);
        chk("wr3_gnt0", {31'd0, gnt0}, 32'd1);
        chk("wr3_we_a", {31'd0, ram_we_a}, 32'd1);
        step();
        set0(0, 0, 0, 0);
        set1(1, 0, 4'd3, 16'h0);
        @(negedge clk);
        chk("rd3_gnt1", {31'd0, gnt1}, 32'd1);
        chk("rd3_rvalid1_before", {31'd0, rvalid1}, 32'd0);
        q1.push_back(16'hBEEF);
        step();
        set1(0, 0, 0, 0);
        @(negedge clk);
        chk("rd3_rvalid1", {31'd0, rvalid1}, 32'd1);
        step();

        // Write-write conflict held two cycles
        set0(1, 1, 4'd5, 16'h1111);
        set1(1, 1, 4'd5, 16'h2222);
        @(negedge clk);
        chk("c1_gnt0", {31'd0, gnt0}, 32'd1);
        chk("c1_gnt1", {31'd0, gnt1}, 32'd0);
        chk("c1_we_b", {31'd0, ram_we_b}, 32'd0);
        step();
        @(negedge clk);
        chk("c2_gnt0", {31'd0, gnt0}, 32'd0);
        chk("c2_gnt1", {31'd0, gnt1}, 32'd1);
        chk("c2_we_a", {31'd0, ram_we_a}, 32'd0);
        chk("c2_we_b", {31'd0, ram_we_b}, 32'd1);
        step();
        set0(0, 0, 0, 0);
        set1(0, 0, 0, 0);
        @(negedge clk);
        chk("conflict_cnt_2", {24'd0, conflict_cnt}, 32'd2);
        chk("mem5", {16'd0, mem[5]}, 32'h2222);
        set0(1, 0, 4'd5, 16'h0);
        q0.push_back(16'h2222);
        step();
        set0(0, 0, 0, 0);

        // Same-address read and write: read sees the old data
        set0(1, 1, 4'd7, 16'hAAAA);
        set1(1, 0, 4'd7, 16'h0);
        @(negedge clk);
        chk("rw7_gnt0", {31'd0, gnt0}, 32'd1);
        chk("rw7_gnt1", {31'd0, gnt1}, 32'd1);
        q1.push_back(16'h0000);
        step();
        set0(0, 0, 0, 0);
        @(negedge clk);
        q1.push_back(16'hAAAA);
        step();
        set1(0, 0, 0, 0);

        // Persistent conflict: alternating winners, counter saturates
        set0(1, 1, 4'd2, 16'h0102);
        set1(1, 1, 4'd2, 16'h0201);
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            chk("rr_gnt0", {31'd0, gnt0}, (i % 2 == 0) ? 32'd1 : 32'd0);
            chk("rr_gnt1", {31'd0, gnt1}, (i % 2 == 0) ? 32'd0 : 32'd1);
            step();
        end
        set0(0, 0, 0, 0);
        set1(0, 0, 0, 0);
        @(negedge clk);
        chk("conflict_cnt_sat", {24'd0, conflict_cnt}, 32'd255);
        step();

        // Reset right after a granted read: no rvalid, clear restarts at 0
        set0(1, 0, 4'd4, 16'h0);
        @(negedge clk);
        chk("pre_rst_gnt0", {31'd0, gnt0}, 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        set0(0, 0, 0, 0);
        @(negedge clk);
        chk("rst_rvalid0", {31'd0, rvalid0}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd1);
        chk("rst_cnt", {24'd0, conflict_cnt}, 32'd0);
        for (int i = 0; i < 16; i++) begin
            if (i > 0) @(negedge clk);
            chk("reinit_adr_a", {28'd0, ram_adr_a}, i);
            chk("reinit_busy", {31'd0, busy}, 32'd1);
            step();
        end
        @(negedge clk);
        chk("reinit_done_busy", {31'd0, busy}, 32'd0);
        step();
        step();
        chk("q0_drained", q0.size(), 32'd0);
        chk("q1_drained", q1.size(), 32'd0);
        done = 1'b1;
        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
